// File: rtl/reg_alu_datapath.sv
// Register file + bypass muxes + 8-function ALU datapath.
// Result/flag register drives dout and the controller status flags.
module reg_alu_datapath #(
  parameter int M = 3,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic [M-1:0] waddr,
  input  logic [M-1:0] ra,
  input  logic [M-1:0] rb,
  input  logic [2:0]   op,
  input  logic         ie,
  input  logic         write,
  input  logic         reada,
  input  logic         readb,
  input  logic         en,
  input  logic         oe,
  input  logic [N-1:0] offset,
  input  logic         bypassa,
  input  logic         bypassb,
  output logic [N-1:0] dout,
  output logic         o_flag,
  output logic         z_flag,
  output logic         n_flag
);

  localparam int          DEPTH = 2 ** M;
  localparam logic [N-1:0] ONE  = N'(1);

  logic [N-1:0] r_rf [DEPTH];
  logic [N-1:0] r_res;
  logic         r_o;
  logic         r_z;
  logic         r_n;

  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic [N-1:0] w_opa;
  logic [N-1:0] w_opb;
  logic [N-1:0] w_alu;
  logic [N-1:0] w_wdata;
  logic         w_ovf;

  // Gated read ports, then immediate bypass onto each operand.
  always_comb begin
    w_a   = reada ? r_rf[ra] : '0;
    w_b   = readb ? r_rf[rb] : '0;
    w_opa = bypassa ? offset : w_a;
    w_opb = bypassb ? offset : w_b;
  end

  // ALU; overflow only meaningful for the arithmetic ops.
  always_comb begin
    w_alu = '0;
    w_ovf = 1'b0;
    unique case (op)
      3'b000: begin
        w_alu = w_opa + w_opb;
        w_ovf = (w_opa[N-1] == w_opb[N-1]) &&
                (w_alu[N-1] != w_opa[N-1]);
      end
      3'b001: begin
        w_alu = w_opa - w_opb;
        w_ovf = (w_opa[N-1] != w_opb[N-1]) &&
                (w_alu[N-1] != w_opa[N-1]);
      end
      3'b010: w_alu = w_opa & w_opb;
      3'b011: w_alu = w_opa | w_opb;
      3'b100: w_alu = w_opa ^ w_opb;
      3'b101: w_alu = ~w_opa;
      3'b110: w_alu = w_opa;
      3'b111: begin
        w_alu = w_opa + ONE;
        w_ovf = !w_opa[N-1] && w_alu[N-1];
      end
    endcase
  end

  assign w_wdata = ie ? din : r_res;

  // Register file write; writeback uses the pre-edge result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else if (write) begin
      r_rf[waddr] <= w_wdata;
    end
  end

  // Result and flags load together when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res <= '0;
      r_o   <= 1'b0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
    end else if (en) begin
      r_res <= w_alu;
      r_o   <= w_ovf;
      r_z   <= (w_alu == '0);
      r_n   <= w_alu[N-1];
    end
  end

  assign dout   = oe ? r_res : '0;
  assign o_flag = r_o;
  assign z_flag = r_z;
  assign n_flag = r_n;

endmodule

// File: tb/tb_reg_alu_datapath.sv
// Bench for reg_alu_datapath: directed plan plus random traffic
// against an integer-arithmetic reference model.
module tb_reg_alu_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [2:0] waddr;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [2:0] op;
  logic       ie;
  logic       write;
  logic       reada;
  logic       readb;
  logic       en;
  logic       oe;
  logic [7:0] offset;
  logic       bypassa;
  logic       bypassb;
  logic [7:0] dout;
  logic       o_flag;
  logic       z_flag;
  logic       n_flag;

  int n_vec = 0;
  int n_err = 0;

  int m_rf [8];
  int m_res;
  bit m_o, m_z, m_n;

  reg_alu_datapath #(.M(3), .N(8)) dut (
    .clk(clk), .rst(rst), .din(din), .waddr(waddr),
    .ra(ra), .rb(rb), .op(op), .ie(ie), .write(write),
    .reada(reada), .readb(readb), .en(en), .oe(oe),
    .offset(offset), .bypassa(bypassa), .bypassb(bypassb),
    .dout(dout), .o_flag(o_flag), .z_flag(z_flag),
    .n_flag(n_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference ALU using plain integer arithmetic.
  function automatic void alu_ref(input int f, input int a,
                                  input int b, output int r,
                                  output bit o);
    int s;
    s = 0;
    o = 0;
    case (f)
      0: begin r = (a + b) % 256; s = sgn(a) + sgn(b); o = 1; end
      1: begin r = (a - b + 256) % 256; s = sgn(a) - sgn(b); o = 1; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: r = a;
      default: begin r = (a + 1) % 256; s = sgn(a) + 1; o = 1; end
    endcase
    if (o) o = (s > 127) || (s < -128);
  endfunction

  task automatic model_clear();
    foreach (m_rf[i]) m_rf[i] = 0;
    m_res = 0;
    m_o = 0; m_z = 0; m_n = 0;
  endtask

  task automatic idle();
    din = 0; waddr = 0; ra = 0; rb = 0; op = 0;
    ie = 0; write = 0; reada = 0; readb = 0;
    en = 0; oe = 0; offset = 0; bypassa = 0; bypassb = 0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".dout"}, 32'(dout), oe ? 32'(m_res) : 0);
    chk({tag, ".flags"}, {29'd0, o_flag, z_flag, n_flag},
        {29'd0, m_o, m_z, m_n});
  endtask

  // One clock: predict from pre-edge inputs, commit after the edge.
  task automatic cyc(input string tag);
    int a, b, r, wd;
    bit o;
    a = reada ? m_rf[ra] : 0;
    b = readb ? m_rf[rb] : 0;
    if (bypassa) a = offset;
    if (bypassb) b = offset;
    alu_ref(op, a, b, r, o);
    wd = ie ? int'(din) : m_res;
    @(posedge clk);
    if (rst) begin
      if (write) m_rf[waddr] = wd;
      if (en) begin
        m_res = r; m_o = o; m_z = (r == 0); m_n = (r >= 128);
      end
    end else begin
      model_clear();
    end
    #1;
    chk_out(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 0;
    #1;
    model_clear();
    chk_out(tag);
    #2 rst = 1;
  endtask

  initial begin
    idle();
    model_clear();
    rst = 0;
    oe = 1;
    repeat (3) cyc("rst");
    reada = 1; readb = 1; ra = 5; rb = 6; op = 0; en = 1;
    cyc("rst_rd");
    chk("rst_rd_zero", 32'(dout), 0);
    idle();
    rst = 1;

    ie = 1; write = 1; waddr = 0; din = 8'h02; cyc("ld0");
    waddr = 1; din = 8'h03; cyc("ld1");
    idle();
    reada = 1; readb = 1; ra = 0; rb = 1; op = 3'b000; en = 1;
    cyc("add");
    idle(); oe = 1; #1;
    chk("add_dout", 32'(dout), 32'h05);
    chk("add_flags", {o_flag, z_flag, n_flag}, 3'b000);

    idle();
    write = 1; waddr = 3; op = 3'b111; bypassb = 1; en = 1;
    cyc("wb_inc");
    idle(); oe = 1; #1;
    chk("inc_dout", 32'(dout), 32'h01);
    reada = 1; ra = 3; op = 3'b110; en = 1; oe = 1;
    cyc("rd3");
    chk("rd3_dout", 32'(dout), 32'h05);

    idle(); ie = 1; write = 1; waddr = 2; din = 8'h01; cyc("ld2");
    idle(); bypassa = 1; offset = 8'h7F; readb = 1; rb = 2;
    op = 3'b000; en = 1; oe = 1;
    cyc("ovf");
    chk("ovf_val", {dout, o_flag, z_flag, n_flag}, {8'h80, 3'b101});
    idle(); bypassa = 1; bypassb = 1; offset = 8'h03;
    op = 3'b001; en = 1; oe = 1;
    cyc("sub0");
    chk("sub0_val", {dout, o_flag, z_flag, n_flag}, {8'h00, 3'b010});
    idle(); bypassa = 1; offset = 8'hFF; readb = 1; rb = 2;
    op = 3'b000; en = 1; oe = 1;
    cyc("wrap");
    chk("wrap_val", {dout, o_flag, z_flag, n_flag}, {8'h00, 3'b010});

    idle(); ie = 1; write = 1; waddr = 4; din = 8'h3C; cyc("ld4");
    idle(); bypassa = 1; offset = 8'hF0; readb = 1; rb = 4;
    en = 1; oe = 1;
    op = 3'b010; cyc("and"); chk("and_val", 32'(dout), 32'h30);
    op = 3'b100; cyc("xor"); chk("xor_val", 32'(dout), 32'hCC);
    op = 3'b101; cyc("not"); chk("not_val", 32'(dout), 32'h0F);
    en = 0; op = 3'b000; cyc("hold");
    chk("hold_val", {dout, o_flag, z_flag, n_flag}, {8'h0F, 3'b000});

    oe = 0; #1;
    chk("oe0", 32'(dout), 0);
    oe = 1;
    async_reset("arst");
    idle(); reada = 1; ra = 1; op = 3'b110; en = 1; oe = 1;
    cyc("arst_rd1");
    chk("arst_rd1_zero", 32'(dout), 0);

    for (int k = 0; k < 400; k++) begin
      din = 8'($urandom); waddr = 3'($urandom); ra = 3'($urandom);
      rb = 3'($urandom); op = 3'($urandom); ie = 1'($urandom);
      write = 1'($urandom); reada = 1'($urandom);
      readb = 1'($urandom); en = 1'($urandom); oe = 1'($urandom);
      offset = 8'($urandom); bypassa = ($urandom_range(3) == 0);
      bypassb = ($urandom_range(3) == 0);
      cyc("rnd");
      if ($urandom_range(49) == 0) async_reset("rnd_arst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_alu_datapath.md
Name: reg_alu_datapath

Overview:
- Simple processor datapath: a 2^M x N register file with one write port and two read ports, operand bypass muxes, a combinational 8-function ALU, and a clock-enabled result/flag register.
- Sits under the microcoded controller, which drives the per-cycle control word (ie, write, reada, readb, en, oe, bypassa, bypassb, op, addresses).
- Exposes the result register on dout and the status flags to the controller.

Parameters:
- M, 3, register address width; the register file has 2^M entries.
- N, 8, data word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- din  input  N  external input data.
- waddr  input  M  register-file write address.
- ra  input  M  read address, port A.
- rb  input  M  read address, port B.
- op  input  3  ALU operation select.
- ie  input  1  input enable: 1 = write data is din, 0 = write data is the result register.
- write  input  1  register-file write enable.
- reada  input  1  port A read enable.
- readb  input  1  port B read enable.
- en  input  1  result/flag register load enable.
- oe  input  1  output enable for dout.
- offset  input  N  immediate operand.
- bypassa  input  1  1 = ALU operand A is offset, 0 = port A data.
- bypassb  input  1  1 = ALU operand B is offset, 0 = port B data.
- dout  output  N  result register when oe=1, else 0.
- o_flag  output  1  registered signed-overflow flag.
- z_flag  output  1  registered zero flag.
- n_flag  output  1  registered negative flag.

Behaviour:
- Reset (rst=0, asynchronous): all register-file entries = 0, result register = 0, o/z/n flags = 0, so dout = 0. Reset dominates write and en.
- Register file:
  - Write is synchronous: on the rising edge with write=1, rf[waddr] <= (ie ? din : result_reg).
  - Register 0 is an ordinary writable register.
- Reads are combinational:
  - A = reada ? rf[ra] : 0.
  - B = readb ? rf[rb] : 0.
  - A write and a read of the same address in one cycle returns the old value; the new value is visible after the edge.
- Operand muxes: opA = bypassa ? offset : A; opB = bypassb ? offset : B.
- ALU (combinational, N-bit, wrap-around modulo 2^N):
  - 000 opA+opB
  - 001 opA-opB
  - 010 opA AND opB
  - 011 opA OR opB
  - 100 opA XOR opB
  - 101 NOT opA
  - 110 opA (pass)
  - 111 opA+1
- Flags, computed from the ALU result:
  - z = (result == 0).
  - n = result[N-1].
  - o = two's-complement overflow for ops 000, 001, 111; o = 0 for all other ops.
- Result register: on the rising edge with en=1, result_reg <= ALU result and the flags load together. With en=0, result and flags hold.
- Latency:
  - ALU result is visible on dout one edge after en.
  - Writing an ALU result to the register file needs en in cycle k and write with ie=0 in cycle k+1.
- dout = oe ? result_reg : 0 (combinational from oe).
- Simultaneous write and en in one cycle: the register file stores the pre-edge result_reg; result_reg updates to the new ALU value.
- Reset asserted mid-operation clears all state immediately; no write completes during reset.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> dout=0, all flags 0, any register read returns 0; release rst=1.
- Load and add:
  - Cycle 1: ie=1, write=1, waddr=0, din=0x02. Cycle 2: waddr=1, din=0x03.
  - Cycle 3: reada=readb=1, ra=0, rb=1, op=000, en=1.
  - Cycle 4: oe=1 -> dout=0x05, z=0, n=0, o=0.
- Writeback and increment:
  - After the add, one cycle with ie=0, write=1, waddr=3, op=111, bypassb=1, en=1, reada=0 -> rf[3]=0x05 and result_reg=0x01 (0+1).
  - Next cycle oe=1 -> dout=0x01.
  - A later read of ra=3 gives 0x05.
- Flags:
  - 0x7F+0x01 -> result 0x80, o=1, n=1, z=0.
  - 0x03-0x03 -> 0x00, z=1, o=0.
  - 0xFF+0x01 -> 0x00, z=1, o=0.
- Bypass/logic: bypassa=1, offset=0xF0, port B=0x3C:
  - op=010 -> 0x30.
  - op=100 -> 0xCC.
  - op=101 -> 0x0F.
  - With en=0 -> result and flags hold.
- Output enable and async reset:
  - oe=0 -> dout=0 regardless of the result register.
  - Assert rst=0 between clock edges -> registers and flags clear immediately; a subsequent read of rf[1] returns 0.
